// File: rtl/qdr_req_arb.sv
// qdr_req_arb: shares one QDRII+ MIG user-interface port between two requesters.
// The write and read channels each have their own round-robin arbiter. Every
// issued read pushes the requester ID into a tag FIFO, so that returning read
// data goes back to the requester that issued the read.
// Optional build macro QDR_ARB_STATS_EN adds per-requester grant counters.
module qdr_req_arb #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 144,
    parameter int BW_WIDTH   = 16,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        init_calib_complete,
    input  logic [1:0]                  req_wr_valid,
    output logic [1:0]                  req_wr_ready,
    input  logic [2*ADDR_WIDTH-1:0]     req_wr_addr,
    input  logic [2*DATA_WIDTH-1:0]     req_wr_data,
    input  logic [2*BW_WIDTH-1:0]       req_wr_bw_n,
    input  logic [1:0]                  req_rd_valid,
    output logic [1:0]                  req_rd_ready,
    input  logic [2*ADDR_WIDTH-1:0]     req_rd_addr,
    output logic [1:0]                  req_rd_dvld,
    output logic [DATA_WIDTH-1:0]       req_rd_data,
    output logic                        app_wr_cmd0,
    output logic [ADDR_WIDTH-1:0]       app_wr_addr0,
    output logic [DATA_WIDTH-1:0]       app_wr_data0,
    output logic [BW_WIDTH-1:0]         app_wr_bw_n0,
    output logic                        app_rd_cmd0,
    output logic [ADDR_WIDTH-1:0]       app_rd_addr0,
    input  logic                        app_rd_valid0,
    input  logic [DATA_WIDTH-1:0]       app_rd_data0,
    output logic [$clog2(TAG_DEPTH):0]  rd_outstanding,
    output logic                        rd_tag_err
`ifdef QDR_ARB_STATS_EN
    ,
    input  logic                        stat_clr,
    output logic [63:0]                 stat_wr_cnt,
    output logic [63:0]                 stat_rd_cnt
`endif
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Per-requester views of the packed request buses
    logic [ADDR_WIDTH-1:0] wr_addr_arr [2];
    logic [DATA_WIDTH-1:0] wr_data_arr [2];
    logic [BW_WIDTH-1:0]   wr_bw_arr   [2];
    logic [ADDR_WIDTH-1:0] rd_addr_arr [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign wr_addr_arr[gi] = req_wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wr_data_arr[gi] = req_wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign wr_bw_arr[gi]   = req_wr_bw_n[gi*BW_WIDTH +: BW_WIDTH];
        assign rd_addr_arr[gi] = req_rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end

    logic                wr_ptr_reg;
    logic                rd_ptr_reg;
    logic [1:0]          wr_grant;
    logic [1:0]          rd_grant;
    logic [TAG_DEPTH-1:0] tag_mem;
    logic [PTR_W-1:0]    tag_wr_ptr_reg;
    logic [PTR_W-1:0]    tag_rd_ptr_reg;
    logic [CNT_W-1:0]    tag_cnt_reg;
    logic                tag_full;
    logic                tag_empty;
    logic                tag_push;
    logic                tag_pop;
    logic                head_tag;

    // Two-way round robin: a lone requester always wins, a tie goes to ptr
    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic ptr);
        logic [1:0] g;
        g = 2'b00;
        case (valid)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = ptr ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    // Full uses the registered count only, so a same-cycle pop never frees a slot early
    assign tag_full  = (tag_cnt_reg == CNT_W'(TAG_DEPTH));
    assign tag_empty = (tag_cnt_reg == '0);
    assign head_tag  = tag_mem[tag_rd_ptr_reg];
    assign tag_push  = |rd_grant;
    assign tag_pop   = app_rd_valid0 && !tag_empty;

    // Grant selection; everything is held off until calibration completes
    always_comb begin
        wr_grant = 2'b00;
        rd_grant = 2'b00;
        if (init_calib_complete) begin
            wr_grant = rr_pick(req_wr_valid, wr_ptr_reg);
            if (!tag_full) begin
                rd_grant = rr_pick(req_rd_valid, rd_ptr_reg);
            end
        end
    end

    assign req_wr_ready   = wr_grant;
    assign req_rd_ready   = rd_grant;
    assign rd_outstanding = tag_cnt_reg;

    // Round-robin pointers move to the other requester after each grant
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (|wr_grant) wr_ptr_reg <= ~wr_grant[1];
            if (|rd_grant) rd_ptr_reg <= ~rd_grant[1];
        end
    end

    // Registered MIG commands; address/data/bw hold their last issued value
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            app_wr_cmd0  <= 1'b0;
            app_wr_addr0 <= '0;
            app_wr_data0 <= '0;
            app_wr_bw_n0 <= '0;
            app_rd_cmd0  <= 1'b0;
            app_rd_addr0 <= '0;
        end else begin
            app_wr_cmd0 <= |wr_grant;
            app_rd_cmd0 <= |rd_grant;
            if (|wr_grant) begin
                app_wr_addr0 <= wr_addr_arr[wr_grant[1]];
                app_wr_data0 <= wr_data_arr[wr_grant[1]];
                app_wr_bw_n0 <= wr_bw_arr[wr_grant[1]];
            end
            if (|rd_grant) begin
                app_rd_addr0 <= rd_addr_arr[rd_grant[1]];
            end
        end
    end

    // Tag storage: one requester-ID bit per outstanding read, no reset needed
    always_ff @(posedge sys_clk) begin
        if (tag_push) begin
            tag_mem[tag_wr_ptr_reg] <= rd_grant[1];
        end
    end

    // Tag FIFO pointers and occupancy; an underflowing return leaves them untouched
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tag_wr_ptr_reg <= '0;
            tag_rd_ptr_reg <= '0;
            tag_cnt_reg    <= '0;
        end else begin
            if (tag_push) tag_wr_ptr_reg <= tag_wr_ptr_reg + PTR_W'(1);
            if (tag_pop)  tag_rd_ptr_reg <= tag_rd_ptr_reg + PTR_W'(1);
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt_reg <= tag_cnt_reg + CNT_W'(1);
                2'b01:   tag_cnt_reg <= tag_cnt_reg - CNT_W'(1);
                default: tag_cnt_reg <= tag_cnt_reg;
            endcase
        end
    end

    // Read return: route data valid to the head tag, flag returns with no tag
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            req_rd_dvld <= 2'b00;
            req_rd_data <= '0;
            rd_tag_err  <= 1'b0;
        end else begin
            req_rd_dvld <= tag_pop ? (head_tag ? 2'b10 : 2'b01) : 2'b00;
            if (app_rd_valid0) req_rd_data <= app_rd_data0;
            if (app_rd_valid0 && tag_empty) rd_tag_err <= 1'b1;
        end
    end

`ifdef QDR_ARB_STATS_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_stats
        logic [31:0] wr_cnt_reg;
        logic [31:0] rd_cnt_reg;

        // Saturating grant counters; a clear wins over a same-cycle grant
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                wr_cnt_reg <= '0;
                rd_cnt_reg <= '0;
            end else if (stat_clr) begin
                wr_cnt_reg <= '0;
                rd_cnt_reg <= '0;
            end else begin
                if (wr_grant[gi] && (wr_cnt_reg != 32'hFFFF_FFFF)) wr_cnt_reg <= wr_cnt_reg + 32'd1;
                if (rd_grant[gi] && (rd_cnt_reg != 32'hFFFF_FFFF)) rd_cnt_reg <= rd_cnt_reg + 32'd1;
            end
        end

        assign stat_wr_cnt[gi*32 +: 32] = wr_cnt_reg;
        assign stat_rd_cnt[gi*32 +: 32] = rd_cnt_reg;
    end
`endif

endmodule

// File: tb/tb_qdr_req_arb.sv
// Testbench for qdr_req_arb: a fixed vector table, hand-written corner-case
// sequences, and randomized traffic checked every cycle against a queue-based
// reference model. Build with QDR_ARB_STATS_EN to exercise the counters.
module tb_qdr_req_arb;

    localparam int AW = 18;
    localparam int DW = 144;
    localparam int BW = 16;
    localparam int TD = 16;

    logic            sys_clk;
    logic            sys_rst;
    logic            init_calib_complete;
    logic [1:0]      req_wr_valid;
    logic [1:0]      req_wr_ready;
    logic [2*AW-1:0] req_wr_addr;
    logic [2*DW-1:0] req_wr_data;
    logic [2*BW-1:0] req_wr_bw_n;
    logic [1:0]      req_rd_valid;
    logic [1:0]      req_rd_ready;
    logic [2*AW-1:0] req_rd_addr;
    logic [1:0]      req_rd_dvld;
    logic [DW-1:0]   req_rd_data;
    logic            app_wr_cmd0;
    logic [AW-1:0]   app_wr_addr0;
    logic [DW-1:0]   app_wr_data0;
    logic [BW-1:0]   app_wr_bw_n0;
    logic            app_rd_cmd0;
    logic [AW-1:0]   app_rd_addr0;
    logic            app_rd_valid0;
    logic [DW-1:0]   app_rd_data0;
    logic [4:0]      rd_outstanding;
    logic            rd_tag_err;
`ifdef QDR_ARB_STATS_EN
    logic            stat_clr;
    logic [63:0]     stat_wr_cnt;
    logic [63:0]     stat_rd_cnt;
`endif

    qdr_req_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BW_WIDTH(BW), .TAG_DEPTH(TD)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
        .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready), .req_wr_addr(req_wr_addr),
        .req_wr_data(req_wr_data), .req_wr_bw_n(req_wr_bw_n),
        .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready), .req_rd_addr(req_rd_addr),
        .req_rd_dvld(req_rd_dvld), .req_rd_data(req_rd_data),
        .app_wr_cmd0(app_wr_cmd0), .app_wr_addr0(app_wr_addr0), .app_wr_data0(app_wr_data0),
        .app_wr_bw_n0(app_wr_bw_n0), .app_rd_cmd0(app_rd_cmd0), .app_rd_addr0(app_rd_addr0),
        .app_rd_valid0(app_rd_valid0), .app_rd_data0(app_rd_data0),
        .rd_outstanding(rd_outstanding), .rd_tag_err(rd_tag_err)
`ifdef QDR_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
`endif
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who won last, queue of outstanding requester IDs
    int            wr_last;
    int            rd_last;
    int            tagq[$];
    int            last_wg;
    int            last_rg;
    logic          exp_err;
    logic          exp_wr_cmd;
    logic [AW-1:0] exp_wr_addr;
    logic [DW-1:0] exp_wr_data;
    logic [BW-1:0] exp_bw;
    logic          exp_rd_cmd;
    logic [AW-1:0] exp_rd_addr;
    logic [1:0]    exp_dvld;
    logic [DW-1:0] exp_rdata;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Winner under the rules: lone requester wins, a tie goes to whoever did not win last
    function automatic int pick(input logic calib, input logic [1:0] v, input int last, input bit room);
        if (!calib || !room) return -1;
        if (v == 2'b11) return 1 - last;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        wr_last = 1; rd_last = 1;
        tagq.delete();
        last_wg = -1; last_rg = -1;
        exp_err = 1'b0; exp_wr_cmd = 1'b0; exp_rd_cmd = 1'b0;
        exp_wr_addr = '0; exp_wr_data = '0; exp_bw = '0; exp_rd_addr = '0;
        exp_dvld = 2'b00; exp_rdata = '0;
    endtask

    task automatic idle_inputs();
        init_calib_complete = 1'b0;
        req_wr_valid = 2'b00; req_rd_valid = 2'b00;
        app_rd_valid0 = 1'b0;
`ifdef QDR_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_cmd"},  DW'(app_wr_cmd0), '0);
        check({tag, "_wr_addr"}, DW'(app_wr_addr0), '0);
        check({tag, "_wr_data"}, app_wr_data0, '0);
        check({tag, "_wr_bw"},   DW'(app_wr_bw_n0), '0);
        check({tag, "_rd_cmd"},  DW'(app_rd_cmd0), '0);
        check({tag, "_rd_addr"}, DW'(app_rd_addr0), '0);
        check({tag, "_dvld"},    DW'(req_rd_dvld), '0);
        check({tag, "_rdata"},   req_rd_data, '0);
        check({tag, "_outst"},   DW'(rd_outstanding), '0);
        check({tag, "_tagerr"},  DW'(rd_tag_err), '0);
    endtask

    task automatic do_reset();
        idle_inputs();
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        check_zero("reset");
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        model_reset();
    endtask

    // One clock: check readies mid-cycle, advance the model, check registered outputs
    task automatic cycle();
        int wg;
        int rg;
        int tg;
        logic [1:0] gv;
        @(negedge sys_clk);
        wg = pick(init_calib_complete, req_wr_valid, wr_last, 1'b1);
        rg = pick(init_calib_complete, req_rd_valid, rd_last, tagq.size() < TD);
        gv = (wg < 0) ? 2'b00 : (2'b01 << wg);
        check("wr_ready", DW'(req_wr_ready), DW'(gv));
        gv = (rg < 0) ? 2'b00 : (2'b01 << rg);
        check("rd_ready", DW'(req_rd_ready), DW'(gv));
        exp_wr_cmd = (wg >= 0);
        exp_rd_cmd = (rg >= 0);
        if (wg >= 0) begin
            exp_wr_addr = req_wr_addr[wg*AW +: AW];
            exp_wr_data = req_wr_data[wg*DW +: DW];
            exp_bw      = req_wr_bw_n[wg*BW +: BW];
            wr_last     = wg;
        end
        if (rg >= 0) begin
            exp_rd_addr = req_rd_addr[rg*AW +: AW];
            rd_last     = rg;
        end
        exp_dvld = 2'b00;
        if (app_rd_valid0) begin
            if (tagq.size() > 0) begin
                tg = tagq.pop_front();
                exp_dvld = (tg == 1) ? 2'b10 : 2'b01;
                exp_rdata = app_rd_data0;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (rg >= 0) tagq.push_back(rg);
        last_wg = wg;
        last_rg = rg;
        @(posedge sys_clk); #1;
        check("wr_cmd",  DW'(app_wr_cmd0), DW'(exp_wr_cmd));
        check("wr_addr", DW'(app_wr_addr0), DW'(exp_wr_addr));
        check("wr_data", app_wr_data0, exp_wr_data);
        check("wr_bw",   DW'(app_wr_bw_n0), DW'(exp_bw));
        check("rd_cmd",  DW'(app_rd_cmd0), DW'(exp_rd_cmd));
        check("rd_addr", DW'(app_rd_addr0), DW'(exp_rd_addr));
        check("dvld",    DW'(req_rd_dvld), DW'(exp_dvld));
        if (exp_dvld != 2'b00) check("rd_data", req_rd_data, exp_rdata);
        check("outstanding", DW'(rd_outstanding), DW'(tagq.size()));
        check("tag_err", DW'(rd_tag_err), DW'(exp_err));
    endtask

    typedef struct {
        logic       calib;
        logic [1:0] wv;
        logic [1:0] rv;
        logic [1:0] exp_wr_rdy;
        logic [1:0] exp_rd_rdy;
    } vec_t;

    vec_t vtab[8];
    bit   wpend[2];
    bit   rpend[2];

    initial begin
        int cnt;
        int acc;
        logic [AW-1:0] wa_exp[4];
        logic [BW-1:0] bw_exp[4];

        sys_rst = 1'b1;
        idle_inputs();
        req_wr_addr = '0; req_wr_data = '0; req_wr_bw_n = '0; req_rd_addr = '0;
        app_rd_data0 = '0;
        model_reset();
        #3;
        do_reset();

        // ---- Table vectors from reset: expected readies follow the round-robin rules
        vtab[0] = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00};
        vtab[1] = '{1'b1, 2'b11, 2'b11, 2'b01, 2'b01};
        vtab[2] = '{1'b1, 2'b11, 2'b11, 2'b10, 2'b10};
        vtab[3] = '{1'b1, 2'b10, 2'b00, 2'b10, 2'b00};
        vtab[4] = '{1'b1, 2'b11, 2'b10, 2'b01, 2'b10};
        vtab[5] = '{1'b1, 2'b01, 2'b11, 2'b01, 2'b01};
        vtab[6] = '{1'b1, 2'b11, 2'b11, 2'b10, 2'b10};
        vtab[7] = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00};
        req_wr_addr = {18'h2AAAA, 18'h15555};
        req_rd_addr = {18'h0F00F, 18'h00FF0};
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            init_calib_complete = vtab[i].calib;
            req_wr_valid = vtab[i].wv;
            req_rd_valid = vtab[i].rv;
            #2;
            check("tab_wr_ready", DW'(req_wr_ready), DW'(vtab[i].exp_wr_rdy));
            check("tab_rd_ready", DW'(req_rd_ready), DW'(vtab[i].exp_rd_rdy));
            cycle();
            if (vtab[i].exp_rd_rdy != 2'b00) cnt++;
            check("tab_wr_cmd", DW'(app_wr_cmd0), DW'(vtab[i].exp_wr_rdy != 2'b00));
            check("tab_outst", DW'(rd_outstanding), DW'(cnt));
        end

        // ---- Calibration gating, then write round robin with bw_n pass-through
        do_reset();
        req_wr_addr = {18'h20000, 18'h00010};
        req_wr_bw_n = {16'hA5A5, 16'h0F0F};
        req_wr_data = {rand_data(), rand_data()};
        req_wr_valid = 2'b11;
        req_rd_valid = 2'b11;
        for (int i = 0; i < 20; i++) cycle();
        check("gate_wr_cmd", DW'(app_wr_cmd0), '0);
        wa_exp = '{18'h00010, 18'h20000, 18'h00010, 18'h20000};
        bw_exp = '{16'h0F0F, 16'hA5A5, 16'h0F0F, 16'hA5A5};
        init_calib_complete = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_wr_cmd", DW'(app_wr_cmd0), DW'(1'b1));
            check("rr_wr_addr", DW'(app_wr_addr0), DW'(wa_exp[i]));
            check("rr_wr_bw", DW'(app_wr_bw_n0), DW'(bw_exp[i]));
        end

        // ---- Read routing: req1 then req0, data returns in issue order
        do_reset();
        init_calib_complete = 1'b1;
        req_rd_addr = {18'h00100, 18'h00200};
        req_rd_valid = 2'b10;
        cycle();
        check("route_rd_addr1", DW'(app_rd_addr0), DW'(18'h00100));
        req_rd_valid = 2'b01;
        cycle();
        check("route_rd_addr0", DW'(app_rd_addr0), DW'(18'h00200));
        req_rd_valid = 2'b00;
        app_rd_valid0 = 1'b1;
        app_rd_data0 = {16'hD1D1, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
        cycle();
        check("route_dvld_d1", DW'(req_rd_dvld), DW'(2'b10));
        check("route_data_d1", req_rd_data, {16'hD1D1, 128'h1111_2222_3333_4444_5555_6666_7777_8888});
        app_rd_data0 = {16'hD0D0, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000};
        cycle();
        check("route_dvld_d0", DW'(req_rd_dvld), DW'(2'b01));
        check("route_data_d0", req_rd_data, {16'hD0D0, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000});
        app_rd_valid0 = 1'b0;
        cycle();
        check("route_dvld_idle", DW'(req_rd_dvld), '0);

        // ---- Tag FIFO full: exactly TD accepted, a pop at full still blocks the push
        do_reset();
        init_calib_complete = 1'b1;
        req_rd_valid = 2'b01;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (app_rd_cmd0) acc++;
        end
        check("full_accepted", DW'(acc), DW'(16));
        check("full_outst", DW'(rd_outstanding), DW'(16));
        check("full_ready", DW'(req_rd_ready), '0);
        app_rd_valid0 = 1'b1;
        app_rd_data0 = rand_data();
        cycle();
        check("full_pop_no_push", DW'(app_rd_cmd0), '0);
        check("full_outst_15", DW'(rd_outstanding), DW'(15));
        app_rd_valid0 = 1'b0;
        cycle();
        check("full_next_accept", DW'(app_rd_cmd0), DW'(1'b1));
        check("full_outst_16", DW'(rd_outstanding), DW'(16));

        // ---- Underflow sets a sticky error without a dvld pulse
        do_reset();
        init_calib_complete = 1'b1;
        app_rd_valid0 = 1'b1;
        app_rd_data0 = rand_data();
        cycle();
        check("uflow_err", DW'(rd_tag_err), DW'(1'b1));
        check("uflow_dvld", DW'(req_rd_dvld), '0);
        app_rd_valid0 = 1'b0;
        cycle();
        check("uflow_sticky", DW'(rd_tag_err), DW'(1'b1));

        // ---- Asynchronous reset in the middle of a burst
        req_wr_valid = 2'b11;
        req_rd_valid = 2'b11;
        for (int i = 0; i < 3; i++) cycle();
        #2;
        sys_rst = 1'b1;
        #1;
        check_zero("async_rst");
        idle_inputs();
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        model_reset();
        app_rd_valid0 = 1'b1;
        cycle();
        check("stray_after_rst", DW'(rd_tag_err), DW'(1'b1));
        app_rd_valid0 = 1'b0;

`ifdef QDR_ARB_STATS_EN
        // ---- Grant statistics and clear priority
        do_reset();
        check("stat_rst_wr", DW'(stat_wr_cnt), '0);
        check("stat_rst_rd", DW'(stat_rd_cnt), '0);
        init_calib_complete = 1'b1;
        req_wr_valid = 2'b01;
        req_rd_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) req_rd_valid = 2'b00;
            cycle();
        end
        req_wr_valid = 2'b00;
        check("stat_wr0", DW'(stat_wr_cnt[31:0]), DW'(5));
        check("stat_wr1", DW'(stat_wr_cnt[63:32]), '0);
        check("stat_rd0", DW'(stat_rd_cnt[31:0]), '0);
        check("stat_rd1", DW'(stat_rd_cnt[63:32]), DW'(3));
        stat_clr = 1'b1;
        req_wr_valid = 2'b01;
        cycle();
        stat_clr = 1'b0;
        req_wr_valid = 2'b00;
        check("stat_clr_wr", DW'(stat_wr_cnt), '0);
        check("stat_clr_rd", DW'(stat_rd_cnt), '0);
`endif

        // ---- Randomized traffic against the reference model
        do_reset();
        wpend = '{0, 0};
        rpend = '{0, 0};
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (wpend[i] && last_wg == i) wpend[i] = 1'b0;
                if (rpend[i] && last_rg == i) rpend[i] = 1'b0;
                if (!wpend[i] && $urandom_range(1, 0) == 1) begin
                    wpend[i] = 1'b1;
                    req_wr_addr[i*AW +: AW] = AW'($urandom);
                    req_wr_data[i*DW +: DW] = rand_data();
                    req_wr_bw_n[i*BW +: BW] = BW'($urandom);
                end
                if (!rpend[i] && $urandom_range(1, 0) == 1) begin
                    rpend[i] = 1'b1;
                    req_rd_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            req_wr_valid = {wpend[1], wpend[0]};
            req_rd_valid = {rpend[1], rpend[0]};
            init_calib_complete = ($urandom_range(19, 0) != 0);
            if (tagq.size() > 0) app_rd_valid0 = ($urandom_range(2, 0) == 0);
            else                 app_rd_valid0 = ($urandom_range(99, 0) == 0);
            app_rd_data0 = rand_data();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
